// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage types, reset/exception defaults and branch target helper
package mips_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0180;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

  // Word offset is relative to the delay-slot address (pc + 4).
  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                input logic [15:0] offset);
    return pc_plus4 + {{14{offset[15]}}, offset, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_next_pc_sel.sv
// rtl/fetch_pc_unit_next_pc_sel.sv - redirect target compute and next-PC priority mux (PC_ALIGN_CHECK_EN)
module next_pc_sel
  import mips_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_plus4_i,
  input  logic        accept_i,
  input  logic        branch_taken_i,
  input  logic [15:0] branch_offset_i,
  input  logic        jump_en_i,
  input  logic [25:0] jump_target_i,
  input  logic        jr_en_i,
  input  logic [31:0] jr_addr_i,
  output logic [31:0] next_pc_o,
  output logic        misalign_o,
  output logic [31:0] target_o
);

  logic redirect;

  assign redirect = jr_en_i | jump_en_i | branch_taken_i;

  always_comb begin
    target_o = branch_target(pc_plus4_i, branch_offset_i);
    if (jr_en_i) begin
      target_o = jr_addr_i;
    end else if (jump_en_i) begin
      target_o = {pc_plus4_i[31:28], jump_target_i, 2'b00};
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_comb begin
    next_pc_o  = pc_i;
    misalign_o = 1'b0;
    if (redirect) begin
      // Only a register target can carry low address bits.
      if (target_o[1:0] != 2'b00) begin
        next_pc_o  = EXC_VECTOR;
        misalign_o = 1'b1;
      end else begin
        next_pc_o = target_o;
      end
    end else if (accept_i) begin
      next_pc_o = pc_plus4_i;
    end
  end
`else
  logic unused_exc;

  assign unused_exc = ^EXC_VECTOR;
  assign misalign_o = 1'b0;

  always_comb begin
    next_pc_o = pc_i;
    if (redirect) begin
      next_pc_o = {target_o[31:2], 2'b00};
    end else if (accept_i) begin
      next_pc_o = pc_plus4_i;
    end
  end
`endif

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch-stage PC register, BOOT/RUN/HALT control and imem request (PC_ALIGN_CHECK_EN)
module fetch_pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             halt,
  input  logic             resume,
  input  logic             branch_taken,
  input  logic [15:0]      branch_offset,
  input  logic             jump_en,
  input  logic [25:0]      jump_target,
  input  logic             jr_en,
  input  logic [31:0]      jr_addr,
  input  logic             imem_req_ready,
  output logic             imem_req_valid,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [CNT_W-1:0] fetch_count,
  output logic             misalign_err,
  output logic [31:0]      bad_addr
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run;
  logic             accept;
  logic             sel_misalign;
  logic [31:0]      sel_target;

  assign run            = (state_q == ST_RUN);
  assign imem_req_valid = run & ~stall;
  assign accept         = imem_req_valid & imem_req_ready;
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + INSTR_BYTES;
  assign fetch_count    = cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (halt) state_d = ST_HALT;
      ST_HALT: if (resume && !halt) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  assign cnt_d = accept ? cnt_q + CNT_W'(1) : cnt_q;

  // Redirects are qualified by RUN here so BOOT and HALT leave the PC frozen.
  next_pc_sel #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_pc_sel (
    .pc_i            (pc_q),
    .pc_plus4_i      (pc_plus4),
    .accept_i        (accept),
    .branch_taken_i  (branch_taken & run),
    .branch_offset_i (branch_offset),
    .jump_en_i       (jump_en & run),
    .jump_target_i   (jump_target),
    .jr_en_i         (jr_en & run),
    .jr_addr_i       (jr_addr),
    .next_pc_o       (pc_d),
    .misalign_o      (sel_misalign),
    .target_o        (sel_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic        misalign_q;
  logic [31:0] bad_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      misalign_q <= sel_misalign;
      if (sel_misalign) begin
        bad_addr_q <= sel_target;
      end
    end
  end

  assign misalign_err = misalign_q;
  assign bad_addr     = bad_addr_q;
`else
  logic unused_sel;

  assign unused_sel   = ^{sel_misalign, sel_target};
  assign misalign_err = 1'b0;
  assign bad_addr     = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed plus randomized bench for fetch_pc_unit against a behavioural model
module tb_fetch_pc_unit;

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;
  localparam logic [31:0] EXC = 32'h0000_0180;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, halt, resume, branch_taken, jump_en, jr_en, imem_req_ready;
  logic [15:0] branch_offset;
  logic [25:0] jump_target;
  logic [31:0] jr_addr;
  logic        imem_req_valid;
  logic [31:0] pc, pc_plus4, fetch_count, bad_addr;
  logic        misalign_err;

  int          n_total = 0;
  int          n_pass  = 0;

  int          m_state;
  logic [31:0] m_pc, m_cnt, m_bad;
  logic        m_mis;

  fetch_pc_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .halt           (halt),
    .resume         (resume),
    .branch_taken   (branch_taken),
    .branch_offset  (branch_offset),
    .jump_en        (jump_en),
    .jump_target    (jump_target),
    .jr_en          (jr_en),
    .jr_addr        (jr_addr),
    .imem_req_ready (imem_req_ready),
    .imem_req_valid (imem_req_valid),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .fetch_count    (fetch_count),
    .misalign_err   (misalign_err),
    .bad_addr       (bad_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic idle();
    stall = 0; halt = 0; resume = 0; branch_taken = 0; jump_en = 0; jr_en = 0;
    imem_req_ready = 1; branch_offset = '0; jump_target = '0; jr_addr = '0;
  endtask

  task automatic model_reset();
    m_state = M_BOOT; m_pc = 32'h0; m_cnt = 32'h0; m_mis = 0; m_bad = 32'h0;
  endtask

  // Plain arithmetic restatement of the fetch rules, applied once per rising edge.
  task automatic model_step();
    logic [31:0] seq, tgt;
    bit          acc, redir;
    seq   = m_pc + 32'd4;
    acc   = (m_state == M_RUN) && !stall && imem_req_ready;
    redir = (m_state == M_RUN) && (jr_en || jump_en || branch_taken);
    if (jr_en)        tgt = jr_addr;
    else if (jump_en) tgt = (seq & 32'hF000_0000) + 32'(jump_target) * 4;
    else              tgt = seq + 32'(int'($signed(branch_offset)) * 4);
    m_mis = 0;
    if (redir) begin
`ifdef PC_ALIGN_CHECK_EN
      if (tgt % 4 != 0) begin
        m_pc = EXC; m_mis = 1; m_bad = tgt;
      end else m_pc = tgt;
`else
      m_pc = tgt - (tgt % 4);
`endif
    end else if (acc) m_pc = seq;
    if (acc) m_cnt = m_cnt + 1;
    case (m_state)
      M_BOOT:  m_state = M_RUN;
      M_RUN:   if (halt) m_state = M_HALT;
      default: if (resume && !halt) m_state = M_RUN;
    endcase
  endtask

  task automatic check_all();
    chk("valid",    {31'b0, imem_req_valid}, {31'b0, (m_state == M_RUN) && !stall});
    chk("pc",       pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("count",    fetch_count, m_cnt);
    chk("misalign", {31'b0, misalign_err}, {31'b0, m_mis});
    chk("bad_addr", bad_addr, m_bad);
  endtask

  // Entered in the low phase with inputs already set; returns at the next falling edge.
  task automatic cyc();
    #1 check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    rst_n = 1;

    jr_en = 1; jr_addr = 32'h400;
    cyc();
    chk("boot_ignores_jr", pc, 32'h0);
    idle();
    repeat (2) cyc();
    imem_req_ready = 0;
    repeat (3) cyc();
    chk("notready_pc", pc, 32'h8);
    chk("notready_cnt", fetch_count, 32'd2);
    #1 chk("notready_valid", {31'b0, imem_req_valid}, 32'h1);
    imem_req_ready = 1;
    cyc();
    chk("resume_pc", pc, 32'hC);
    chk("three_accepts", fetch_count, 32'd3);

    idle(); jr_en = 1; jr_addr = 32'h100;
    cyc();
    idle(); imem_req_ready = 0; branch_taken = 1; branch_offset = 16'hFFFE;
    cyc();
    chk("branch_back", pc, 32'h0FC);

    idle(); jr_en = 1; jr_addr = 32'h1000_0000;
    cyc();
    idle(); jump_en = 1; jump_target = 26'h40;
    cyc();
    chk("jump", pc, 32'h1000_0100);

    idle(); jr_en = 1; jump_en = 1; branch_taken = 1;
    jr_addr = 32'h400; jump_target = 26'h123; branch_offset = 16'h5;
    cyc();
    chk("jr_priority", pc, 32'h400);
    idle(); stall = 1; jr_en = 1; jr_addr = 32'h400;
    cyc();
    chk("stall_jr", pc, 32'h400);

    idle(); jr_en = 1; jr_addr = 32'hFFFF_FFFC;
    cyc();
    idle();
    cyc();
    chk("pc_wrap", pc, 32'h0);

    idle(); halt = 1;
    cyc();
    jr_en = 1; jr_addr = 32'h800;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("halt_frozen", pc, 32'h4);
      chk("halt_valid", {31'b0, imem_req_valid}, 32'h0);
    end
    idle(); resume = 1;
    cyc();
    idle();
    #1;
    chk("resumed_pc", pc, 32'h4);
    chk("resumed_valid", {31'b0, imem_req_valid}, 32'h1);
    cyc();

    idle(); jr_en = 1; jr_addr = 32'h402;
    cyc();
`ifdef PC_ALIGN_CHECK_EN
    chk("misalign_pc", pc, EXC);
    chk("misalign_pulse", {31'b0, misalign_err}, 32'h1);
    chk("misalign_addr", bad_addr, 32'h402);
    idle();
    cyc();
    chk("misalign_clear", {31'b0, misalign_err}, 32'h0);
`else
    chk("forced_align", pc, 32'h400);
    chk("no_misalign", {31'b0, misalign_err}, 32'h0);
    idle();
    cyc();
`endif

    for (int i = 0; i < 400; i++) begin
      stall          = ($urandom % 5) == 0;
      imem_req_ready = ($urandom % 4) != 0;
      jr_en          = ($urandom % 16) == 0;
      jump_en        = ($urandom % 16) == 0;
      branch_taken   = ($urandom % 8) == 0;
      halt           = ($urandom % 24) == 0;
      resume         = ($urandom % 3) == 0;
      branch_offset  = 16'($urandom);
      jump_target    = 26'($urandom);
      jr_addr        = $urandom;
      cyc();
    end

    idle();
    repeat (3) cyc();
    rst_n = 0;
    #1;
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("async_rst_cnt", fetch_count, 32'h0);
    chk("async_rst_mis", {31'b0, misalign_err}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (4) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
